// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub operand sequencer.
//   - seq_state_t        : sequencer FSM states
//   - DEF_WIDTH          : default operand/sum width
//   - DEF_SETTLE_CYCLES  : default adder settle time in clock periods
//   - signed_limit()     : signed max/min pattern used when saturating
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int SAT_MAX_W         = 64;

    // Signed maximum (neg = 0) or signed minimum (neg = 1) for a given width,
    // returned zero-extended; callers size-cast to their own width.
    function automatic logic [SAT_MAX_W-1:0] signed_limit(input int width, input logic neg);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i == width - 1) begin
                r[i] = neg;
            end else if (i < width - 1) begin
                r[i] = ~neg;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_op_sequencer_if.sv
// Operand and result streams of the add/sub sequencer.
//   in_valid/in_ready, in_a, in_b, in_cin, in_sel : operand stream
//   out_valid/out_ready, out_sum, out_cout, out_ovf : result stream
// master: producer of operands / consumer of results.
// slave : the sequencer.
interface addsub_op_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sel;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sel, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sel, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/full_adder_8_bit_gate.sv
// Gate-level 8-bit ripple add/sub.
//   a, b     : operands
//   c_in     : carry-in (add)
//   sel      : 0 = a+b+c_in, 1 = a+~b+(c_in^1), i.e. a-b when c_in = 0
//   sum      : result
//   c_out    : carry out of bit 7
//   over_flow: signed overflow (carry into MSB xor carry out)
module full_adder_8_bit_gate (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    input  logic       sel,
    output logic [7:0] sum,
    output logic       c_out,
    output logic       over_flow
);
    wire [7:0] bx;
    wire [7:0] p;
    wire [7:0] g;
    wire [7:0] t;
    wire [8:0] c;
    wire [7:0] s;
    wire       co;
    wire       ov;

    xor (c[0], c_in, sel);

    for (genvar i = 0; i < 8; i++) begin : g_bit
        xor (bx[i], b[i], sel);
        xor (p[i], a[i], bx[i]);
        xor (s[i], p[i], c[i]);
        and (g[i], a[i], bx[i]);
        and (t[i], p[i], c[i]);
        or  (c[i+1], g[i], t[i]);
    end

    buf (co, c[8]);
    xor (ov, c[7], c[8]);

    assign sum       = s;
    assign c_out     = co;
    assign over_flow = ov;
endmodule

// File: rtl/addsub_op_sequencer.sv
// Clocked front-end for a combinational add/sub adder.
// Accepts one operand set, drives it to the adder from registers, waits
// SETTLE_CYCLES clock periods, then captures sum/carry/overflow and offers
// them on the result stream until taken.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   bus (slave)         : operand stream in, result stream out
//   add_a/add_b/add_cin/add_sel : registered adder inputs
//   add_sum/add_cout/add_ovf    : adder outputs
//   busy                : high in SETTLE or HOLD
//
// Build option ADDSUB_SEQ_SAT_EN: on overflow the captured sum is clamped
// to the signed max/min chosen by the sign of add_a.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand set
// SETTLE | adder inputs held, counter running down
// HOLD   | result captured, out_valid high until out_ready
module addsub_op_sequencer
    import addsub_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    output logic                 add_sel,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    input  logic                 add_ovf,
    output logic                 busy
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;

    logic             load_en;
    logic             cap_en;
    logic             rel_en;
    logic [WIDTH-1:0] cap_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.in_valid)            state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == CNT_W'(1))        state_nxt = ST_HOLD;
            ST_HOLD:   if (bus.out_ready)           state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == ST_IDLE) && !rst;
        busy         = (state == ST_SETTLE) || (state == ST_HOLD);
        load_en      = (state == ST_IDLE) && bus.in_valid;
        cap_en       = (state == ST_SETTLE) && (cnt == CNT_W'(1));
        rel_en       = (state == ST_HOLD) && bus.out_ready;
    end

`ifdef ADDSUB_SEQ_SAT_EN
    always_comb begin
        cap_sum = add_sum;
        if (add_ovf) begin
            cap_sum = WIDTH'(signed_limit(WIDTH, add_a[WIDTH-1]));
        end
    end
`else
    assign cap_sum = add_sum;
`endif

    // Counter reaches 0 only on the capture edge and is reloaded on accept,
    // so the decrement guard never fires in practice but keeps it from wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_en) begin
            cnt <= CNT_W'(SETTLE_CYCLES);
        end else if (state == ST_SETTLE && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            add_sel <= 1'b0;
        end else if (load_en) begin
            add_a   <= bus.in_a;
            add_b   <= bus.in_b;
            add_cin <= bus.in_cin;
            add_sel <= bus.in_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else if (cap_en) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= cap_sum;
            bus.out_cout  <= add_cout;
            bus.out_ovf   <= add_ovf;
        end else if (rel_en) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_op_sequencer.sv
module tb_addsub_op_sequencer;
    import addsub_pkg::*;

    localparam int W  = 8;
    localparam int SC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    addsub_op_sequencer_if #(.WIDTH(W)) bus0 ();
    addsub_op_sequencer_if #(.WIDTH(W)) bus1 ();

    logic [W-1:0] a0_a, a0_b, a0_sum, a1_a, a1_b, a1_sum;
    logic         a0_cin, a0_sel, a0_cout, a0_ovf, a1_cin, a1_sel, a1_cout, a1_ovf;
    logic         busy0, busy1;

    addsub_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .add_a(a0_a), .add_b(a0_b), .add_cin(a0_cin), .add_sel(a0_sel),
        .add_sum(a0_sum), .add_cout(a0_cout), .add_ovf(a0_ovf), .busy(busy0)
    );
    full_adder_8_bit_gate adder0 (
        .a(a0_a), .b(a0_b), .c_in(a0_cin), .sel(a0_sel),
        .sum(a0_sum), .c_out(a0_cout), .over_flow(a0_ovf)
    );

    addsub_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .add_a(a1_a), .add_b(a1_b), .add_cin(a1_cin), .add_sel(a1_sel),
        .add_sum(a1_sum), .add_cout(a1_cout), .add_ovf(a1_ovf), .busy(busy1)
    );
    full_adder_8_bit_gate adder1 (
        .a(a1_a), .b(a1_b), .c_in(a1_cin), .sel(a1_sel),
        .sum(a1_sum), .c_out(a1_cout), .over_flow(a1_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sel);
        int ua, ub, sa, sb, r, sr;
        logic [7:0] s;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (!sel) begin
            r  = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            co = (r > 255);
        end else begin
            r  = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end
        s  = 8'((r + 256) % 256);
        ov = (sr > 127) || (sr < -128);
`ifdef ADDSUB_SEQ_SAT_EN
        if (ov) s = (sa >= 0) ? 8'h7F : 8'h80;
`endif
        return {ov, co, s};
    endfunction

    // One full transaction on dut0; hold = cycles of backpressure in HOLD,
    // poke = drive a different operand set during that backpressure.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sel, input int hold, input logic poke, input string tag);
        int n;
        logic [9:0] exp;
        logic [9:0] first;
        exp = model(a, b, cin, sel);
        n = 0;
        while (!bus0.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, ":ready_before"}, 32'(bus0.in_ready), 32'd1);
        bus0.in_valid = 1'b1;
        bus0.in_a = a; bus0.in_b = b; bus0.in_cin = cin; bus0.in_sel = sel;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk({tag, ":add_drive"}, {14'd0, a0_sel, a0_cin, a0_a, a0_b}, {14'd0, sel, cin, a, b});
        chk({tag, ":busy"}, 32'(busy0), 32'd1);
        n = 0;
        while (!bus0.out_valid && n < 300) begin
            chk({tag, ":in_ready_low"}, 32'(bus0.in_ready), 32'd0);
            @(posedge clk); #1; n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'(SC));
        first = {bus0.out_ovf, bus0.out_cout, bus0.out_sum};
        chk({tag, ":result"}, 32'(first), 32'(exp));
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                bus0.in_valid = 1'b1;
                bus0.in_a = ~a;
            end
            @(posedge clk); #1;
            chk({tag, ":hold_stable"}, {21'd0, bus0.out_valid, bus0.out_ovf, bus0.out_cout, bus0.out_sum},
                {21'd0, 1'b1, first});
            chk({tag, ":hold_in_ready"}, 32'(bus0.in_ready), 32'd0);
            if (poke) chk({tag, ":hold_add_a"}, 32'(a0_a), 32'(a));
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        chk({tag, ":released"}, 32'(bus0.out_valid), 32'd0);
        chk({tag, ":ready_after"}, 32'(bus0.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic rs, rc;
        logic [9:0] e1;

        rst = 1'b1;
        bus0.in_valid = 0; bus0.in_a = 0; bus0.in_b = 0; bus0.in_cin = 0; bus0.in_sel = 0; bus0.out_ready = 0;
        bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.in_cin = 0; bus1.in_sel = 0; bus1.out_ready = 0;
        #1;
        chk("reset_outs", {8'd0, bus0.out_valid, bus0.out_ovf, bus0.out_cout, busy0, bus0.in_ready, 3'd0, bus0.out_sum, a0_a},
            32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_in_ready", 32'(bus0.in_ready), 32'd1);

        run_op(8'h55, 8'h44, 1'b0, 1'b0, 0, 1'b0, "t1_add_ovf");
        run_op(8'hFF, 8'h55, 1'b0, 1'b0, 0, 1'b0, "t2_add_cout");
        run_op(8'hBB, 8'h44, 1'b0, 1'b0, 0, 1'b0, "t2_add_ff");
        run_op(8'h55, 8'h44, 1'b0, 1'b1, 0, 1'b0, "t3_sub_pos");
        run_op(8'h11, 8'h55, 1'b0, 1'b1, 0, 1'b0, "t3_sub_neg");
        run_op(8'h12, 8'h34, 1'b1, 1'b0, 5, 1'b1, "t4_backpressure");
        run_op(8'hED, 8'h01, 1'b0, 1'b0, 0, 1'b0, "t4_after_poke");

        // Reset while SETTLE has counter at 2
        @(posedge clk); #1;
        bus0.in_valid = 1'b1; bus0.in_a = 8'h70; bus0.in_b = 8'h22; bus0.in_cin = 0; bus0.in_sel = 0;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_clear", {12'd0, bus0.out_valid, busy0, a0_cin, a0_sel, a0_a, a0_b}, 32'd0);
        chk("t5_rst_in_ready", 32'(bus0.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t5_post_rst_ready", 32'(bus0.in_ready), 32'd1);
        chk("t5_post_rst_out", {23'd0, bus0.out_valid, bus0.out_sum}, 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("t5_no_stale_result", 32'(bus0.out_valid), 32'd0);
        run_op(8'h70, 8'h22, 1'b0, 1'b0, 1, 1'b0, "t5_after_rst");

        // SETTLE_CYCLES = 1 instance
        e1 = model(8'h7F, 8'h01, 1'b0, 1'b0);
        bus1.in_valid = 1'b1; bus1.in_a = 8'h7F; bus1.in_b = 8'h01;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk("t6_not_yet", 32'(bus1.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("t6_valid_one_edge", 32'(bus1.out_valid), 32'd1);
        chk("t6_result", 32'({bus1.out_ovf, bus1.out_cout, bus1.out_sum}), 32'(e1));
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("t6_release", {30'd0, bus1.out_valid, bus1.in_ready}, 32'd1);

        // Randomized operand sets
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            rc = rs ? 1'b0 : 1'($urandom);
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/addsub_op_sequencer.md
Name: addsub_op_sequencer

Overview:
- Clocked front-end that issues one operand set at a time to the gate-level 8-bit add/sub adder (`full_adder_8_bit_gate`).
- Holds the adder inputs stable for a programmable number of settle cycles, so gate delays resolve, then registers sum, carry-out and overflow.
- Upstream side is a valid/ready operand stream; downstream side is a valid/ready result stream.
- Sits directly upstream of the adder and also captures its outputs.

Parameters:
- WIDTH, 8, operand/sum width; must match the adder instance.
- SETTLE_CYCLES, 3, clock periods the adder inputs are held before results are sampled; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  sequencer can accept an operand set
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in
- in_sel  in  1  0 = add, 1 = subtract
- add_a  out  WIDTH  registered drive to adder a
- add_b  out  WIDTH  registered drive to adder b
- add_cin  out  1  registered drive to adder c_in
- add_sel  out  1  registered drive to adder sel
- add_sum  in  WIDTH  adder sum
- add_cout  in  1  adder c_out
- add_ovf  in  1  adder over_flow
- out_valid  out  1  result registered and pending
- out_ready  in  1  consumer takes result
- out_sum  out  WIDTH  captured sum
- out_cout  out  1  captured carry-out
- out_ovf  out  1  captured overflow
- busy  out  1  high in SETTLE or HOLD

Behaviour:
- Reset (async, active-high, fixed): state = IDLE; add_*, out_*, out_valid and counter all 0; busy = 0.
- in_ready = (state == IDLE) and not rst.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: an edge with in_valid & in_ready accepts the operands.
  - Accepting edge T0: add_a/add_b/add_cin/add_sel load in_a/in_b/in_cin/in_sel.
  - Counter loads SETTLE_CYCLES; next state is SETTLE.
- SETTLE: the counter decrements each edge.
  - At the edge where counter == 1 (edge T0+SETTLE_CYCLES), out_sum/out_cout/out_ovf capture add_sum/add_cout/add_ovf.
  - At that same edge out_valid is set to 1 and the FSM moves to HOLD.
  - The adder inputs are stable for exactly SETTLE_CYCLES full periods before sampling.
- HOLD: out_* remain stable while out_valid = 1.
  - An edge with out_ready = 1 clears out_valid and returns to IDLE.
  - in_ready rises in the cycle after that edge. No bypass.
- add_* keep their last value in IDLE and HOLD; they are not cleared.
- in_valid while busy is ignored. The upstream must hold in_valid and its data until in_ready; the sequencer does not buffer.
- Latency: accept edge to out_valid high is SETTLE_CYCLES edges.
- Throughput: at most one op per SETTLE_CYCLES+2 cycles.
- Counter width is clog2(SETTLE_CYCLES+1); it never underflows, and SETTLE_CYCLES = 1 gives a one-cycle SETTLE.
- out_ready asserted outside HOLD is ignored.
- Reset mid-SETTLE or mid-HOLD: immediate return to reset values; any pending result is discarded.
- Arithmetic: the block does none itself. All result fields come from the adder unmodified, except as described under Optional Feature.

Optional Feature:
- Macro: ADDSUB_SEQ_SAT_EN.
- Defined: at capture, if add_ovf = 1, out_sum is saturated rather than taken from add_sum.
  - If add_a[WIDTH-1] = 0, out_sum = the signed maximum (0x7F for WIDTH = 8).
  - Otherwise out_sum = the signed minimum (0x80).
  - This rule holds for both add and subtract. out_ovf still reports 1, and out_cout is passed unmodified.
- Undefined: out_sum = add_sum always, with two's-complement wrap.

Decomposition:
- Shared package addsub_pkg holds:
  - the state enum (IDLE/SETTLE/HOLD);
  - the default WIDTH and SETTLE_CYCLES constants;
  - the signed max/min helper used by saturation.
- No sub-module is needed; the counter and FSM stay inline.
- The bench instantiates the sequencer together with full_adder_8_bit_gate (unit delays).
- Expected values assume the adder computes a+b+cin for sel=0 and a−b for sel=1 with cin=0, with c_out being the two's-complement carry.

Test Plan:
1. Add 0x55+0x44, cin 0, SETTLE 3 → out_valid 3 edges after accept; sum 0x99, cout 0, ovf 1 (0x7F with ADDSUB_SEQ_SAT_EN).
2. Add 0xFF+0x55 → sum 0x54, cout 1, ovf 0; with 0xBB+0x44 back-to-back → sum 0xFF, cout 0, ovf 0; in_ready low from accept until the cycle after the result handshake.
3. Subtract 0x55−0x44 → sum 0x11, cout 1, ovf 0; subtract 0x11−0x55 → sum 0xBC, cout 0, ovf 0.
4. Backpressure: out_ready low for 5 cycles in HOLD → out_sum/out_valid stable throughout; a changed in_a in that window has no effect on the next result until the sequencer accepts again.
5. Assert rst for 1 cycle in SETTLE (counter 2) → out_valid 0, add_* 0, in_ready 1 after reset; a new op then completes normally.
6. SETTLE_CYCLES = 1 → out_valid one edge after accept with the correct sum.
